// File: rtl/c_wb_pkg.sv
// c_wb_pkg: shared definitions for the C-buffer writeback/readback controller.
//   FUNCT_*     CFU funct codes decoded by c_wb_ctrl
//   wb_state_e  writeback FSM states
package c_wb_pkg;

    localparam logic [2:0] FUNCT_CLEAR  = 3'd1;
    localparam logic [2:0] FUNCT_CONFIG = 3'd2;
    localparam logic [2:0] FUNCT_SET_RD = 3'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/c_addr_gen.sv
// c_addr_gen: row/tile counters and write-index generation for the C buffer.
//   clk, rst      clock, async active-high reset
//   clr           zero row/tile counters (base kept)
//   load, base_in load a new base and zero the counters
//   adv           one row accepted: step row counter, roll into tile counter
//   idx           base + tile*ROWS + row, truncated to IDX_W
//   in_range      full-width index < DEPTH
//   last_row      current row is the last row of the tile
module c_addr_gen
    import c_wb_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int IDX_W  = 16,
    parameter int DEPTH  = 4096,
    parameter int TILE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [IDX_W-1:0] base_in,
    input  logic             adv,
    output logic [IDX_W-1:0] idx,
    output logic             in_range,
    output logic             last_row
);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int ADDR_W = IDX_W + TILE_W;

    logic [IDX_W-1:0]  base;
    logic [ROW_W-1:0]  row_cnt;
    logic [TILE_W-1:0] tile_cnt;
    logic [ADDR_W-1:0] full_idx;

    // Full-width sum so an index past 2^IDX_W is still caught by the DEPTH compare.
    assign full_idx = ADDR_W'(base) + ADDR_W'(tile_cnt) * ADDR_W'(ROWS) + ADDR_W'(row_cnt);
    assign idx      = full_idx[IDX_W-1:0];
    assign in_range = 64'(full_idx) < 64'(DEPTH);
    assign last_row = (row_cnt == ROW_W'(ROWS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base     <= '0;
            row_cnt  <= '0;
            tile_cnt <= '0;
        end else if (clr) begin
            row_cnt  <= '0;
            tile_cnt <= '0;
        end else if (load) begin
            base     <= base_in;
            row_cnt  <= '0;
            tile_cnt <= '0;
        end else if (adv) begin
            if (last_row) begin
                row_cnt  <= '0;
                tile_cnt <= tile_cnt + TILE_W'(1);
            end else begin
                row_cnt  <= row_cnt + ROW_W'(1);
            end
        end
    end

endmodule

// File: rtl/c_wb_ctrl.sv
// c_wb_ctrl: C-buffer writeback/readback address controller.
//   clk, rst_n     clock; rst_n is ASYNC ACTIVE-HIGH (1 = reset)
//   cmd_valid, funct, input0, input1   CFU command (CLEAR / CONFIG / SET_RD)
//   c_in_signal    array presents one valid C row
//   rd_strobe      CFU consumed the word at c_idx_out
//   c_wr_en, c_idx_in   registered C-buffer write port
//   c_idx_out      registered read index
//   busy           FSM not IDLE
//   tile_done      pulse aligned with the last row's write slot
//   ovf            sticky: a write was suppressed (index >= DEPTH)
// Build option: define C_RD_AUTOINC_EN to make rd_strobe post-increment c_idx_out.
module c_wb_ctrl
    import c_wb_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int IDX_W  = 16,
    parameter int DEPTH  = 4096,
    parameter int TILE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [2:0]       funct,
    input  logic [31:0]      input0,
    input  logic [31:0]      input1,
    input  logic             c_in_signal,
    input  logic             rd_strobe,
    output logic             c_wr_en,
    output logic [IDX_W-1:0] c_idx_in,
    output logic [IDX_W-1:0] c_idx_out,
    output logic             busy,
    output logic             tile_done,
    output logic             ovf
);
    wb_state_e        state, state_nxt;
    logic             is_clr, is_cfg, is_rd, cmd_hit, accept;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             in_range, last_row;
    logic             unused_hi;

    assign is_clr  = cmd_valid && (funct == FUNCT_CLEAR);
    assign is_cfg  = cmd_valid && (funct == FUNCT_CONFIG);
    assign is_rd   = cmd_valid && (funct == FUNCT_SET_RD);
    assign cmd_hit = is_clr || is_cfg || is_rd;

    // A recognised command wins the cycle; the row strobed alongside it is dropped.
    assign accept = c_in_signal && !cmd_hit && (state == IDLE || state == WRITE);

    // Low product bits depend only on low operand bits, so IDX_W math gives the truncated result.
    assign rd_idx    = input0[IDX_W-1:0] + input1[IDX_W-1:0] * IDX_W'(ROWS);
    assign unused_hi = ^{input0[31:IDX_W], input1[31:IDX_W]};

    c_addr_gen #(
        .ROWS   (ROWS),
        .IDX_W  (IDX_W),
        .DEPTH  (DEPTH),
        .TILE_W (TILE_W)
    ) u_addr (
        .clk      (clk),
        .rst      (rst_n),
        .clr      (is_clr),
        .load     (is_cfg && state == IDLE),
        .base_in  (input0[IDX_W-1:0]),
        .adv      (accept),
        .idx      (wr_idx),
        .in_range (in_range),
        .last_row (last_row)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= IDLE;
        else       state <= state_nxt;
    end

    // HOLD waits for the strobe to drop so a still-high strobe is not taken as a new tile.
    always_comb begin
        state_nxt = state;
        if (is_clr)
            state_nxt = IDLE;
        else if (accept)
            state_nxt = last_row ? HOLD : WRITE;
        else if (state == HOLD && !c_in_signal)
            state_nxt = IDLE;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            c_wr_en   <= 1'b0;
            c_idx_in  <= '0;
            tile_done <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            c_wr_en   <= accept && in_range;
            tile_done <= accept && last_row;
            if (accept)
                c_idx_in <= wr_idx;
            if (is_clr)
                ovf <= 1'b0;
            else if (accept && !in_range)
                ovf <= 1'b1;
        end
    end

`ifdef C_RD_AUTOINC_EN
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)          c_idx_out <= '0;
        else if (is_clr)    c_idx_out <= '0;
        else if (is_rd)     c_idx_out <= rd_idx;
        else if (rd_strobe) c_idx_out <= c_idx_out + IDX_W'(1);
    end
`else
    logic unused_rd;
    assign unused_rd = rd_strobe;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)       c_idx_out <= '0;
        else if (is_clr) c_idx_out <= '0;
        else if (is_rd)  c_idx_out <= rd_idx;
    end
`endif

endmodule

// File: tb/tb_c_wb_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed writes into per-DUT queues,
// a negedge monitor pops and compares whenever a DUT shows c_wr_en or tile_done.
// Two DUTs share stimulus: default DEPTH and DEPTH=16 for the bounds case.
module tb_c_wb_ctrl;
    import c_wb_pkg::*;

    logic        clk = 0;
    logic        rst_n = 1;
    logic        cmd_valid = 0;
    logic [2:0]  funct = 0;
    logic [31:0] input0 = 0, input1 = 0;
    logic        c_in_signal = 0, rd_strobe = 0;

    logic        wr_a, done_a, busy_a, ovf_a;
    logic [15:0] idx_a, out_a;
    logic        wr_b, done_b, busy_b, ovf_b;
    logic [15:0] idx_b, out_b;

    int checks = 0;
    int errors = 0;

    // entry = {wr, done, idx}
    logic [17:0] qa[$];
    logic [17:0] qb[$];

    always #5 clk = ~clk;

    c_wb_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .funct(funct),
        .input0(input0), .input1(input1), .c_in_signal(c_in_signal), .rd_strobe(rd_strobe),
        .c_wr_en(wr_a), .c_idx_in(idx_a), .c_idx_out(out_a), .busy(busy_a),
        .tile_done(done_a), .ovf(ovf_a)
    );

    c_wb_ctrl #(.DEPTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .funct(funct),
        .input0(input0), .input1(input1), .c_in_signal(c_in_signal), .rd_strobe(rd_strobe),
        .c_wr_en(wr_b), .c_idx_in(idx_b), .c_idx_out(out_b), .busy(busy_b),
        .tile_done(done_b), .ovf(ovf_b)
    );

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Expected write of one row; DEPTH=16 copy only writes below 16 but still pulses tile_done.
    task automatic push_row(input logic [15:0] idx, input logic last);
        qa.push_back({1'b1, last, idx});
        if (idx < 16)  qb.push_back({1'b1, last, idx});
        else if (last) qb.push_back({1'b0, 1'b1, idx});
    endtask

    task automatic step(input logic cin);
        c_in_signal = cin;
        @(posedge clk); #1;
    endtask

    task automatic cmd(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic cin);
        cmd_valid = 1; funct = f; input0 = a; input1 = b; c_in_signal = cin;
        @(posedge clk); #1;
        cmd_valid = 0; funct = 0; input0 = 0; input1 = 0; c_in_signal = 0;
    endtask

    always @(negedge clk) begin
        logic [17:0] e;
        if (wr_a || done_a) begin
            if (qa.size() == 0) cmp("a_unexpected_write", {wr_a, done_a, idx_a}, 18'h0);
            else begin e = qa.pop_front(); cmp("a_write", {wr_a, done_a, idx_a}, e); end
        end
        if (wr_b || done_b) begin
            if (qb.size() == 0) cmp("b_unexpected_write", {wr_b, done_b, idx_b}, 18'h0);
            else begin e = qb.pop_front(); cmp("b_write", {wr_b, done_b, idx_b}, e); end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_outputs", {wr_a, done_a, busy_a, ovf_a, idx_a, out_a}, 0);
        rst_n = 0;
        step(0);

        // 1: one tile at base 0x10
        cmd(FUNCT_CONFIG, 32'h10, 0, 0);
        for (int i = 0; i < 4; i++) push_row(16'h10 + 16'(i), i == 3);
        for (int i = 0; i < 4; i++) step(1);
        step(0);

        // 2: strobe stays high for 6 cycles -> 4 writes, then HOLD
        for (int i = 0; i < 4; i++) push_row(16'h14 + 16'(i), i == 3);
        for (int i = 0; i < 6; i++) step(1);
        cmp("hold_busy", busy_a, 1);
        step(0);
        cmp("hold_released", busy_a, 0);

        // 3: gapped strobe, fresh base 0x20
        cmd(FUNCT_CONFIG, 32'h20, 0, 0);
        for (int i = 0; i < 4; i++) push_row(16'h20 + 16'(i), i == 3);
        step(1); step(0); step(1); step(1); step(0); step(1);
        step(0);
        cmp("gap_idle", busy_a, 0);

        // 4: DEPTH=16 bound, base 14
        cmd(FUNCT_CLEAR, 0, 0, 0);
        cmp("b_ovf_cleared", ovf_b, 0);
        cmd(FUNCT_CONFIG, 32'd14, 0, 0);
        for (int i = 0; i < 4; i++) push_row(16'd14 + 16'(i), i == 3);
        for (int i = 0; i < 4; i++) step(1);
        step(0);
        cmp("b_ovf_set", ovf_b, 1);
        cmp("a_ovf_clear", ovf_a, 0);
        step(0);
        cmp("b_ovf_sticky", ovf_b, 1);
        cmd(FUNCT_CLEAR, 0, 0, 0);
        cmp("b_ovf_after_clear", ovf_b, 0);

        // 5: read index
        cmd(FUNCT_SET_RD, 32'd2, 32'd3, 0);
        cmp("set_rd", out_a, 16'd14);
        rd_strobe = 1;
        repeat (3) step(0);
        rd_strobe = 0;
`ifdef C_RD_AUTOINC_EN
        cmp("rd_autoinc", out_a, 16'd17);
`else
        cmp("rd_no_autoinc", out_a, 16'd14);
`endif
        rd_strobe = 1;
        cmd(FUNCT_SET_RD, 32'd0, 32'd5, 0);
        rd_strobe = 0;
        cmp("set_rd_priority", out_a, 16'd20);

        // 6: CLEAR on the 3rd row, then reset mid-tile (base still 14, counters zeroed)
        push_row(16'd14, 0); push_row(16'd15, 0);
        step(1); step(1);
        cmd(FUNCT_CLEAR, 0, 0, 1);
        cmp("clear_no_write", wr_a, 0);
        cmp("clear_idle", busy_a, 0);
        cmp("clear_rd_idx", out_a, 0);
        push_row(16'd14, 0);
        step(1);
        step(0);
        cmp("mid_tile_busy", busy_a, 1);
        #2 rst_n = 1;
        #1 cmp("async_reset", {wr_a, done_a, busy_a, ovf_a, idx_a, out_a}, 0);
        @(posedge clk); #1;
        rst_n = 0;
        push_row(16'd0, 0);
        step(1);
        step(0);
        repeat (3) step(0);

        cmp("a_queue_drained", qa.size(), 0);
        cmp("b_queue_drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
